// File: rtl/move_entry.sv
// move_entry
// ----------
// Player-input front end for the triangles-vs-circles game. It is the
// producer side of the move interface that the display/game logic consumes.
// Three raw push-buttons are synchronised and debounced. Presses on
// logic_1/logic_0 shift bits into an 8-bit coordinate, newest bit in bit 0.
// An activity press then either cancels a partial entry or submits a full
// one. A full entry is split into x = bits[7:4] and y = bits[3:0]. When both
// are on the grid, the move is offered downstream.
//
// Handshake: move_valid comes straight from a flop and never depends on
// move_ready. Once raised, move_valid and move_x/move_y/move_player hold
// steady until a clock edge samples move_valid & move_ready. That edge
// completes the transfer. move_ready has no effect while move_valid is low.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset
//   activity_button  raw button, submits or cancels the entry
//   logic_1_button   raw button, enters a 1 bit
//   logic_0_button   raw button, enters a 0 bit
//   move_valid       move offered downstream
//   move_ready       downstream accepts the move
//   move_x, move_y   column / row of the offered move
//   move_player      owner of the offered move / current turn (0 = triangle)
//   entry_bits       bits entered so far, newest in bit 0
//   bit_count        number of bits entered, 0..8
//   entry_error      one-cycle pulse on a rejected or cancelled entry
module move_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GRID_SIZE       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activity_button,
    input  logic       logic_1_button,
    input  logic       logic_0_button,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [3:0] move_x,
    output logic [3:0] move_y,
    output logic       move_player,
    output logic [7:0] entry_bits,
    output logic [3:0] bit_count,
    output logic       entry_error
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [4:0]      GRID_LIM = 5'(GRID_SIZE);

    // Button index: 2 = activity, 1 = logic_1, 0 = logic_0.
    localparam int B_ACT = 2;
    localparam int B_L1  = 1;
    localparam int B_L0  = 0;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        OFFER   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, debouncer, rising-edge detector
    // ------------------------------------------------------------------
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    deb_q, deb_d;
    logic [2:0]    deb_prev_q, deb_prev_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    press;

    assign raw = {activity_button, logic_1_button, logic_0_button};

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                // The counter reaches CNT_MAX while the mismatch persists.
                // The level is accepted on the next edge, so a level that
                // is stable before edge 0 flips at edge 2 + DEBOUNCE_CYCLES.
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Only rising edges of the debounced level are presses.
    assign press = deb_q & ~deb_prev_q;

    // Activity beats a logic press. logic_1 and logic_0 together cancel out.
    logic act_press;
    logic logic_press;
    logic logic_bit;

    assign act_press   = press[B_ACT];
    assign logic_press = (press[B_L1] ^ press[B_L0]) & ~press[B_ACT];
    assign logic_bit   = press[B_L1];

    // ------------------------------------------------------------------
    // Entry / offer FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] entry_bits_q, entry_bits_d;
    logic [3:0] bit_count_q, bit_count_d;
    logic       move_valid_q, move_valid_d;
    logic [3:0] move_x_q, move_x_d;
    logic [3:0] move_y_q, move_y_d;
    logic       move_player_q, move_player_d;
    logic       entry_error_q, entry_error_d;
    logic       coord_ok;

    assign coord_ok = ({1'b0, entry_bits_q[7:4]} < GRID_LIM) &&
                      ({1'b0, entry_bits_q[3:0]} < GRID_LIM);

    always_comb begin
        state_d       = state_q;
        entry_bits_d  = entry_bits_q;
        bit_count_d   = bit_count_q;
        move_valid_d  = move_valid_q;
        move_x_d      = move_x_q;
        move_y_d      = move_y_q;
        move_player_d = move_player_q;
        entry_error_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (act_press) begin
                    entry_bits_d  = '0;
                    bit_count_d   = '0;
                    entry_error_d = 1'b1;
                end else if (logic_press) begin
                    entry_bits_d = {entry_bits_q[6:0], logic_bit};
                    bit_count_d  = bit_count_q + 4'd1;
                    if (bit_count_q == 4'd7) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (act_press) begin
                    if (coord_ok) begin
                        move_x_d     = entry_bits_q[7:4];
                        move_y_d     = entry_bits_q[3:0];
                        move_valid_d = 1'b1;
                        state_d      = OFFER;
                    end else begin
                        entry_bits_d  = '0;
                        bit_count_d   = '0;
                        entry_error_d = 1'b1;
                        state_d       = COLLECT;
                    end
                end
            end
            OFFER: begin
                // Button presses are dropped here on purpose. The player
                // has to wait for the move to be taken.
                if (move_valid_q && move_ready) begin
                    move_valid_d  = 1'b0;
                    move_player_d = ~move_player_q;
                    entry_bits_d  = '0;
                    bit_count_d   = '0;
                    state_d       = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= COLLECT;
            entry_bits_q  <= '0;
            bit_count_q   <= '0;
            move_valid_q  <= 1'b0;
            move_x_q      <= '0;
            move_y_q      <= '0;
            move_player_q <= 1'b0;
            entry_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_bits_q  <= entry_bits_d;
            bit_count_q   <= bit_count_d;
            move_valid_q  <= move_valid_d;
            move_x_q      <= move_x_d;
            move_y_q      <= move_y_d;
            move_player_q <= move_player_d;
            entry_error_q <= entry_error_d;
        end
    end

    assign move_valid  = move_valid_q;
    assign move_x      = move_x_q;
    assign move_y      = move_y_q;
    assign move_player = move_player_q;
    assign entry_bits  = entry_bits_q;
    assign bit_count   = bit_count_q;
    assign entry_error = entry_error_q;

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry with DEBOUNCE_CYCLES = 4 and GRID_SIZE = 10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_move_entry;

    logic       clk;
    logic       reset;
    logic       activity_button;
    logic       logic_1_button;
    logic       logic_0_button;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_x;
    logic [3:0] move_y;
    logic       move_player;
    logic [7:0] entry_bits;
    logic [3:0] bit_count;
    logic       entry_error;

    int total = 0;
    int bad   = 0;

    move_entry #(
        .DEBOUNCE_CYCLES(4),
        .GRID_SIZE      (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .activity_button(activity_button),
        .logic_1_button (logic_1_button),
        .logic_0_button (logic_0_button),
        .move_valid     (move_valid),
        .move_ready     (move_ready),
        .move_x         (move_x),
        .move_y         (move_y),
        .move_player    (move_player),
        .entry_bits     (entry_bits),
        .bit_count      (bit_count),
        .entry_error    (entry_error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Holds the raw buttons high for 8 cycles, then low for 10 cycles.
    // It returns how many sampled cycles showed entry_error high.
    task automatic press(input logic a, input logic l1, input logic l0,
                         output int err_cycles);
        err_cycles = 0;
        activity_button = a;
        logic_1_button  = l1;
        logic_0_button  = l0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (entry_error === 1'b1) err_cycles++;
        end
        activity_button = 1'b0;
        logic_1_button  = 1'b0;
        logic_0_button  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (entry_error === 1'b1) err_cycles++;
        end
    endtask

    // Enters a byte MSB first, so it ends up in entry_bits as written.
    task automatic enter_byte(input logic [7:0] v);
        int e;
        for (int i = 7; i >= 0; i--) begin
            press(1'b0, v[i], ~v[i], e);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        activity_button = 1'b0;
        logic_1_button  = 1'b0;
        logic_0_button  = 1'b0;
        move_ready      = 1'b0;
        wait_cycles(3);
        total++;
        if ({move_valid, move_x, move_y, move_player, entry_bits, bit_count, entry_error} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d p=%b bits=%h cnt=%0d err=%b, want all 0",
                     move_valid, move_x, move_y, move_player, entry_bits, bit_count, entry_error);
        end
        reset = 1'b0;
        wait_cycles(2);
        total++;
        if ({move_valid, bit_count, entry_error} !== 6'd0) begin
            bad++;
            $display("FAIL reset_release: got valid=%b cnt=%0d err=%b, want 0", move_valid, bit_count, entry_error);
        end
    endtask

    task automatic test_debounce();
        int e;
        // A 3-cycle glitch must not be accepted.
        logic_1_button = 1'b1;
        wait_cycles(3);
        logic_1_button = 1'b0;
        wait_cycles(10);
        total++;
        if (bit_count !== 4'd0) begin
            bad++;
            $display("FAIL debounce_glitch: bit_count=%0d want 0", bit_count);
        end
        // A held level updates the state at edge 7, not at edge 6.
        logic_1_button = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 6) begin
                total++;
                if (bit_count !== 4'd0) begin
                    bad++;
                    $display("FAIL debounce_edge6: bit_count=%0d want 0", bit_count);
                end
            end
            if (k == 7) begin
                total++;
                if (bit_count !== 4'd1 || entry_bits !== 8'h01) begin
                    bad++;
                    $display("FAIL debounce_edge7: bit_count=%0d bits=%h want 1 / 01", bit_count, entry_bits);
                end
            end
        end
        logic_1_button = 1'b0;
        wait_cycles(12);
        total++;
        if (bit_count !== 4'd1 || entry_bits !== 8'h01) begin
            bad++;
            $display("FAIL debounce_release: bit_count=%0d bits=%h want 1 / 01", bit_count, entry_bits);
        end
        e = 0;
    endtask

    task automatic test_cancel();
        int e;
        press(1'b0, 1'b0, 1'b1, e);
        press(1'b0, 1'b1, 1'b0, e);
        total++;
        if (bit_count !== 4'd3 || entry_bits !== 8'h05) begin
            bad++;
            $display("FAIL cancel_pre: bit_count=%0d bits=%h want 3 / 05", bit_count, entry_bits);
        end
        press(1'b1, 1'b0, 1'b0, e);
        total++;
        if (e !== 1) begin
            bad++;
            $display("FAIL cancel_err_pulse: error cycles=%0d want 1", e);
        end
        total++;
        if (bit_count !== 4'd0 || entry_bits !== 8'h00) begin
            bad++;
            $display("FAIL cancel_clear: bit_count=%0d bits=%h want 0 / 00", bit_count, entry_bits);
        end
    endtask

    task automatic test_simultaneous();
        int e;
        press(1'b0, 1'b1, 1'b1, e);
        total++;
        if (bit_count !== 4'd0 || entry_bits !== 8'h00 || e !== 0) begin
            bad++;
            $display("FAIL both_logic: bit_count=%0d bits=%h err=%0d want 0 / 00 / 0", bit_count, entry_bits, e);
        end
        press(1'b0, 1'b1, 1'b0, e);
        press(1'b1, 1'b1, 1'b0, e);
        total++;
        if (bit_count !== 4'd0 || e !== 1) begin
            bad++;
            $display("FAIL act_wins: bit_count=%0d err=%0d want 0 / 1", bit_count, e);
        end
    endtask

    task automatic test_out_of_range();
        int e;
        int valid_seen;
        // move_ready is held high outside OFFER and must do nothing.
        move_ready = 1'b1;
        enter_byte(8'hC1);
        total++;
        if (bit_count !== 4'd8 || entry_bits !== 8'hC1 || move_player !== 1'b0) begin
            bad++;
            $display("FAIL oor_full: bit_count=%0d bits=%h p=%b want 8 / c1 / 0", bit_count, entry_bits, move_player);
        end
        press(1'b0, 1'b0, 1'b1, e);
        total++;
        if (bit_count !== 4'd8 || entry_bits !== 8'hC1) begin
            bad++;
            $display("FAIL ninth_press: bit_count=%0d bits=%h want 8 / c1", bit_count, entry_bits);
        end
        valid_seen = 0;
        activity_button = 1'b1;
        e = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) activity_button = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (entry_error === 1'b1) e++;
            if (move_valid !== 1'b0) valid_seen++;
        end
        total++;
        if (e !== 1) begin
            bad++;
            $display("FAIL oor_err_pulse: error cycles=%0d want 1", e);
        end
        total++;
        if (bit_count !== 4'd0 || valid_seen !== 0) begin
            bad++;
            $display("FAIL oor_clear: bit_count=%0d valid cycles=%0d want 0 / 0", bit_count, valid_seen);
        end
        move_ready = 1'b0;
    endtask

    task automatic test_accept();
        int e;
        enter_byte(8'h35);
        press(1'b1, 1'b0, 1'b0, e);
        total++;
        if (move_valid !== 1'b1 || move_x !== 4'd3 || move_y !== 4'd5 || move_player !== 1'b0 || e !== 0) begin
            bad++;
            $display("FAIL accept_offer: valid=%b x=%0d y=%0d p=%b err=%0d want 1/3/5/0/0",
                     move_valid, move_x, move_y, move_player, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (move_valid !== 1'b1 || move_x !== 4'd3 || move_y !== 4'd5) begin
                bad++;
                $display("FAIL accept_hold%0d: valid=%b x=%0d y=%0d want 1/3/5", i, move_valid, move_x, move_y);
            end
        end
        move_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        move_ready = 1'b0;
        total++;
        if (move_valid !== 1'b0 || move_player !== 1'b1 || bit_count !== 4'd0 || entry_bits !== 8'h00) begin
            bad++;
            $display("FAIL accept_handshake: valid=%b p=%b cnt=%0d bits=%h want 0/1/0/00",
                     move_valid, move_player, bit_count, entry_bits);
        end
    endtask

    task automatic test_offer_ignore();
        int e;
        int errs;
        enter_byte(8'h12);
        press(1'b1, 1'b0, 1'b0, e);
        errs = 0;
        press(1'b0, 1'b1, 1'b0, e); errs += e;
        press(1'b0, 1'b0, 1'b1, e); errs += e;
        press(1'b1, 1'b0, 1'b0, e); errs += e;
        total++;
        if (move_valid !== 1'b1 || move_x !== 4'd1 || move_y !== 4'd2 || move_player !== 1'b1 ||
            bit_count !== 4'd8 || entry_bits !== 8'h12 || errs !== 0) begin
            bad++;
            $display("FAIL offer_ignore: valid=%b x=%0d y=%0d p=%b cnt=%0d bits=%h err=%0d want 1/1/2/1/8/12/0",
                     move_valid, move_x, move_y, move_player, bit_count, entry_bits, errs);
        end
        move_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        move_ready = 1'b0;
        wait_cycles(20);
        total++;
        if (move_valid !== 1'b0 || move_player !== 1'b0 || bit_count !== 4'd0 || entry_bits !== 8'h00) begin
            bad++;
            $display("FAIL offer_after: valid=%b p=%b cnt=%0d bits=%h want 0/0/0/00",
                     move_valid, move_player, bit_count, entry_bits);
        end
    endtask

    task automatic test_reset_offer();
        int e;
        // First move flips the turn to player 1.
        enter_byte(8'h99);
        press(1'b1, 1'b0, 1'b0, e);
        move_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        move_ready = 1'b0;
        enter_byte(8'h45);
        press(1'b1, 1'b0, 1'b0, e);
        total++;
        if (move_valid !== 1'b1 || move_player !== 1'b1 || move_x !== 4'd4 || move_y !== 4'd5) begin
            bad++;
            $display("FAIL rst_offer_pre: valid=%b p=%b x=%0d y=%0d want 1/1/4/5", move_valid, move_player, move_x, move_y);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (move_valid !== 1'b0 || move_player !== 1'b0 || move_x !== 4'd0 || move_y !== 4'd0 || bit_count !== 4'd0) begin
            bad++;
            $display("FAIL rst_offer_async: valid=%b p=%b x=%0d y=%0d cnt=%0d want all 0",
                     move_valid, move_player, move_x, move_y, bit_count);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);
        enter_byte(8'h27);
        press(1'b1, 1'b0, 1'b0, e);
        total++;
        if (move_valid !== 1'b1 || move_x !== 4'd2 || move_y !== 4'd7 || move_player !== 1'b0) begin
            bad++;
            $display("FAIL rst_offer_fresh: valid=%b x=%0d y=%0d p=%b want 1/2/7/0", move_valid, move_x, move_y, move_player);
        end
        move_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        move_ready = 1'b0;
        total++;
        if (move_valid !== 1'b0 || move_player !== 1'b1 || bit_count !== 4'd0) begin
            bad++;
            $display("FAIL rst_offer_done: valid=%b p=%b cnt=%0d want 0/1/0", move_valid, move_player, bit_count);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_debounce();
        test_cancel();
        test_simultaneous();
        test_out_of_range();
        test_accept();
        test_offer_ignore();
        test_reset_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_entry.md
Name: move_entry

Overview:
- Player-input front end for the triangles-vs-circles game. It is the producer side of the move interface that the display/game logic consumes.
- Synchronizes and debounces the three raw push-buttons, then assembles an 8-bit grid coordinate from logic_1/logic_0 presses.
- On an activity press it range-checks the coordinate and offers it downstream over a valid/ready handshake.
- Tracks whose turn it is and exposes partial entry state for on-screen echo.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles required before a button level change is accepted (10 ms at 25 MHz); minimum 2.
- GRID_SIZE, 10, number of cells per axis; a coordinate is legal when < GRID_SIZE; range 1..16.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- activity_button  input  1  raw button, active-high, asynchronous to clk
- logic_1_button  input  1  raw button, active-high; enters bit value 1
- logic_0_button  input  1  raw button, active-high; enters bit value 0
- move_valid  output  1  move offered downstream
- move_ready  input  1  downstream accepts move
- move_x  output  4  column of offered move
- move_y  output  4  row of offered move
- move_player  output  1  player owning the offered move / current turn (0 = triangle, 1 = circle)
- entry_bits  output  8  bits entered so far, newest in bit 0
- bit_count  output  4  number of bits entered, 0..8
- entry_error  output  1  one-cycle pulse on rejected or cancelled entry

Behaviour:
- Reset (async): all outputs 0, all sync flops, debounced levels, edge registers and counters 0; state COLLECT.
- Per-button input path:
  - 2-flop synchronizer.
  - Debouncer: counter cleared whenever sync == debounced level, incremented while they differ. The debounced level flips on the edge where the difference has persisted DEBOUNCE_CYCLES cycles, and the counter clears.
  - Press pulse = debounced & ~debounced_prev, where debounced_prev is a registered copy. Releases generate no pulse.
- Timing: a raw level stable from before edge 0 flips the debounced level at edge 2+DEBOUNCE_CYCLES. The resulting state/output update occurs at edge 3+DEBOUNCE_CYCLES.
- Simultaneous press pulses in one cycle:
  - logic_1 and logic_0 together: both ignored.
  - activity together with a logic press: activity wins, logic press ignored.
- State COLLECT (bit_count 0..7):
  - Valid logic press: entry_bits <= {entry_bits[6:0], bit}; bit_count += 1. When bit_count reaches 8, go to FULL.
  - Activity press: cancel. entry_bits and bit_count cleared, entry_error pulses, stay in COLLECT.
- State FULL (bit_count = 8):
  - Logic presses ignored.
  - Activity press: x = entry_bits[7:4], y = entry_bits[3:0].
    - If x < GRID_SIZE and y < GRID_SIZE: move_x/move_y load, move_valid <= 1, go to OFFER.
    - Otherwise: entry_error pulses, entry cleared, go to COLLECT.
- State OFFER:
  - move_valid held high; move_x, move_y, move_player stable until handshake. All button presses ignored (dropped, not queued).
  - Edge where move_valid & move_ready: move_valid <= 0, move_player toggles, entry_bits/bit_count cleared, go to COLLECT.
  - move_ready while not in OFFER has no effect.
  - move_valid never depends combinationally on move_ready.
- entry_error is registered and high for exactly one cycle per event.
- Reset asserted mid-operation (any state, including OFFER) discards the entry and any pending move. move_valid drops immediately and move_player returns to 0.

Test Plan (DEBOUNCE_CYCLES=4, GRID_SIZE=10):
- Accepted move: press 0,0,1,1,0,1,0,1 then activity; hold move_ready=0 for 3 cycles, then 1 → move_valid=1 with move_x=3, move_y=5, move_player=0. One edge after ready: move_valid=0, move_player=1, bit_count=0, entry_bits=0.
- Debounce: logic_1 raw high for 3 cycles then low → no change. Raw held high from before edge 0 → bit_count=1 and entry_bits=0x01 first seen after edge 7, not edge 6. Release → no change.
- Out of range: enter 1,1,0,0,0,0,0,1 (x=12, y=1) then activity → entry_error high exactly 1 cycle, bit_count=0, move_valid stays 0.
- Ignored inputs:
  - 9th logic press in FULL → entry_bits unchanged.
  - logic_1 and logic_0 pulsing in the same cycle → no change.
  - Presses during OFFER → move_x/move_y unchanged, nothing applied after handshake.
- Cancel: 3 bits entered, then activity → entry_error pulse, bit_count=0.
- Reset mid-OFFER (move_valid=1, move_player=1) → move_valid, move_player, move_x, move_y, bit_count all 0 immediately. After release, a fresh 8-bit entry plus activity works normally.
